// File: rtl/bp_fetch_pc_unit.sv
// bp_fetch_pc_unit: IF-stage PC register with a direct-mapped two-bit branch
// predictor. The lookup is combinational on pc_IF. Training and redirects come
// from the EX-stage branch resolution. Statistics counters track resolved
// control transfers and mispredicts.
module bp_fetch_pc_unit #(
    parameter int          ENTRIES  = 16,
    parameter int          IDX_W    = $clog2(ENTRIES),
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_PC,
    input  logic             comp_i,
    input  logic [31:0]      PC_jump_EX,
    input  logic [6:0]       op_ex,
    input  logic [31:0]      pc_EX,
    input  logic             PCSel_EX,
    input  logic [31:0]      alu,
    output logic [31:0]      pc_IF,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    // Predictor table: one entry per index, no associativity.
    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [31:0]      tgt_d   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [1:0]       ctr_d   [ENTRIES];

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, upd;

    // Opcode low bits and the byte offset of pc_EX carry no predictor information.
    logic unused_ok;
    assign unused_ok = ^{op_ex[3:0], pc_EX[1:0]};

    assign lk_idx = pc_q[IDX_W+1:2];
    assign lk_tag = pc_q[31:IDX_W+2];
    assign up_idx = pc_EX[IDX_W+1:2];
    assign up_tag = pc_EX[31:IDX_W+2];

    // BRANCH, JAL and JALR all share opcode bits 110; everything else is a bubble.
    assign upd = (op_ex[6:4] == 3'b110);

    // Lookup reads registered table contents only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? tgt_q[lk_idx] : (pc_q + 32'd4);
    end

    // Next PC: an EX redirect beats a stall, and a stall beats the prediction.
    always_comb begin
        pc_d = pred_target;
        if (comp_i) begin
            pc_d = PC_jump_EX;
        end else if (stall_PC) begin
            pc_d = pc_q;
        end
    end

    // Table training from the EX resolution; the stall does not gate it.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (upd) begin
            if (up_hit) begin
                if (PCSel_EX) begin
                    tgt_d[up_idx] = alu;
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                    end
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
            end else if (PCSel_EX) begin
                // A taken miss allocates as weak-taken, evicting any aliasing entry.
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = alu;
                ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    // Statistics: a redirect without a resolving instruction is not counted.
    always_comb begin
        br_cnt_d      = br_cnt_q + (upd ? CNT_W'(1) : CNT_W'(0));
        mispred_cnt_d = mispred_cnt_q + ((upd && comp_i) ? CNT_W'(1) : CNT_W'(0));
    end

    // State registers; reset invalidates the whole table at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            pc_q          <= pc_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            tgt_q         <= tgt_d;
            ctr_q         <= ctr_d;
        end
    end

    assign pc_IF       = pc_q;
    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bp_fetch_pc_unit.sv
// tb_bp_fetch_pc_unit: directed vector table for bp_fetch_pc_unit plus
// hand-written reset sequences. Each vector row is applied for one clock and
// the outputs are compared just after the edge.
module tb_bp_fetch_pc_unit;

    localparam logic [6:0] NOP  = 7'h13;
    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] SYS  = 7'h73;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_PC;
    logic        comp_i;
    logic [31:0] PC_jump_EX;
    logic [6:0]  op_ex;
    logic [31:0] pc_EX;
    logic        PCSel_EX;
    logic [31:0] alu;
    logic [31:0] pc_IF;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        stall;
        logic        comp;
        logic [31:0] jump;
        logic [6:0]  op;
        logic [31:0] pc_ex;
        logic        sel;
        logic [31:0] alu_v;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic [31:0] e_br;
        logic [31:0] e_mis;
    } vec_t;

    vec_t vecs[$];

    bp_fetch_pc_unit dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .stall_PC    (stall_PC),
        .comp_i      (comp_i),
        .PC_jump_EX  (PC_jump_EX),
        .op_ex       (op_ex),
        .pc_EX       (pc_EX),
        .PCSel_EX    (PCSel_EX),
        .alu         (alu),
        .pc_IF       (pc_IF),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .br_cnt      (br_cnt),
        .mispred_cnt (mispred_cnt)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic stall, input logic comp, input logic [31:0] jump,
                                input logic [6:0] op, input logic [31:0] pc_ex, input logic sel,
                                input logic [31:0] alu_v, input logic [31:0] e_pc, input logic e_pt,
                                input logic [31:0] e_tgt, input logic [31:0] e_br,
                                input logic [31:0] e_mis);
        vec_t v;
        v.stall = stall; v.comp = comp; v.jump = jump; v.op = op; v.pc_ex = pc_ex;
        v.sel = sel; v.alu_v = alu_v; v.e_pc = e_pc; v.e_pt = e_pt; v.e_tgt = e_tgt;
        v.e_br = e_br; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_pt,
                             input logic [31:0] e_tgt, input logic [31:0] e_br,
                             input logic [31:0] e_mis);
        check({tag, " pc_IF"},       pc_IF,              e_pc);
        check({tag, " pred_taken"},  {31'd0, pred_taken}, {31'd0, e_pt});
        check({tag, " pred_target"}, pred_target,         e_tgt);
        check({tag, " br_cnt"},      br_cnt,              e_br);
        check({tag, " mispred_cnt"}, mispred_cnt,         e_mis);
    endtask

    task automatic drive(input logic stall, input logic comp, input logic [31:0] jump,
                         input logic [6:0] op, input logic [31:0] pc_ex, input logic sel,
                         input logic [31:0] alu_v);
        stall_PC = stall; comp_i = comp; PC_jump_EX = jump; op_ex = op;
        pc_EX = pc_ex; PCSel_EX = sel; alu = alu_v;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Columns: stall comp jump op pc_EX sel alu | pc_IF pt target br mis
        vecs.push_back(mk(0, 0, 32'h0,   NOP,  32'h0,  0, 32'h0,   32'h4,   0, 32'h8,   0,  0));
        vecs.push_back(mk(0, 0, 32'h0,   NOP,  32'h0,  0, 32'h0,   32'h8,   0, 32'hC,   0,  0));
        vecs.push_back(mk(0, 0, 32'h0,   NOP,  32'h0,  0, 32'h0,   32'hC,   0, 32'h10,  0,  0));
        vecs.push_back(mk(0, 1, 32'h100, BR,   32'h40, 1, 32'h100, 32'h100, 0, 32'h104, 1,  1));
        vecs.push_back(mk(0, 1, 32'h40,  NOP,  32'h0,  0, 32'h0,   32'h40,  1, 32'h100, 1,  1));
        vecs.push_back(mk(0, 0, 32'h0,   BR,   32'h40, 1, 32'h100, 32'h100, 0, 32'h104, 2,  1));
        vecs.push_back(mk(0, 0, 32'h0,   BR,   32'h40, 1, 32'h100, 32'h104, 0, 32'h108, 3,  1));
        vecs.push_back(mk(0, 1, 32'h44,  BR,   32'h40, 0, 32'h0,   32'h44,  0, 32'h48,  4,  2));
        vecs.push_back(mk(0, 1, 32'h40,  BR,   32'h40, 0, 32'h0,   32'h40,  0, 32'h44,  5,  3));
        vecs.push_back(mk(0, 0, 32'h0,   BR,   32'h40, 0, 32'h0,   32'h44,  0, 32'h48,  6,  3));
        vecs.push_back(mk(0, 1, 32'h40,  BR,   32'h40, 0, 32'h0,   32'h40,  0, 32'h44,  7,  4));
        vecs.push_back(mk(0, 1, 32'h40,  BR,   32'h40, 1, 32'h200, 32'h40,  0, 32'h44,  8,  5));
        vecs.push_back(mk(0, 1, 32'h40,  BR,   32'h40, 1, 32'h200, 32'h40,  1, 32'h200, 9,  6));
        vecs.push_back(mk(0, 1, 32'h20,  NOP,  32'h0,  0, 32'h0,   32'h20,  0, 32'h24,  9,  6));
        vecs.push_back(mk(1, 0, 32'h0,   NOP,  32'h0,  0, 32'h0,   32'h20,  0, 32'h24,  9,  6));
        vecs.push_back(mk(1, 0, 32'h0,   NOP,  32'h0,  0, 32'h0,   32'h20,  0, 32'h24,  9,  6));
        vecs.push_back(mk(1, 0, 32'h0,   NOP,  32'h0,  0, 32'h0,   32'h20,  0, 32'h24,  9,  6));
        vecs.push_back(mk(1, 1, 32'h80,  NOP,  32'h0,  0, 32'h0,   32'h80,  0, 32'h84,  9,  6));
        vecs.push_back(mk(0, 1, 32'h40,  JAL,  32'h80, 1, 32'h300, 32'h40,  0, 32'h44,  10, 7));
        vecs.push_back(mk(0, 1, 32'h80,  NOP,  32'h0,  0, 32'h0,   32'h80,  1, 32'h300, 10, 7));
        vecs.push_back(mk(0, 0, 32'h0,   JALR, 32'h80, 1, 32'h300, 32'h300, 0, 32'h304, 11, 7));
        vecs.push_back(mk(0, 0, 32'h0,   SYS,  32'h8,  1, 32'h500, 32'h304, 0, 32'h308, 11, 7));
        vecs.push_back(mk(0, 1, 32'h8,   NOP,  32'h0,  0, 32'h0,   32'h8,   0, 32'hC,   11, 7));
        vecs.push_back(mk(0, 1, 32'h40,  NOP,  32'h0,  0, 32'h0,   32'h40,  0, 32'h44,  11, 7));
        vecs.push_back(mk(0, 0, 32'h0,   BR,   32'h40, 1, 32'h100, 32'h44,  0, 32'h48,  12, 7));
        vecs.push_back(mk(0, 1, 32'h40,  NOP,  32'h0,  0, 32'h0,   32'h40,  1, 32'h100, 12, 7));
        vecs.push_back(mk(1, 0, 32'h0,   BR,   32'h40, 0, 32'h0,   32'h40,  0, 32'h44,  13, 7));

        // Reset state
        rst_ni = 1'b0;
        drive(0, 0, 32'h0, NOP, 32'h0, 0, 32'h0);
        #1;
        check_all("reset", 32'h0, 0, 32'h4, 0, 0);
        step();
        step();
        rst_ni = 1'b1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].comp, vecs[i].jump, vecs[i].op,
                  vecs[i].pc_ex, vecs[i].sel, vecs[i].alu_v);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pt, vecs[i].e_tgt,
                      vecs[i].e_br, vecs[i].e_mis);
        end

        // Mid-cycle async reset with a taken branch pending in EX
        drive(0, 0, 32'h0, BR, 32'h0, 1, 32'h600);
        #3;
        rst_ni = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 0, 32'h4, 0, 0);
        step();
        check_all("rst_held", 32'h0, 0, 32'h4, 0, 0);
        drive(0, 0, 32'h0, NOP, 32'h0, 0, 32'h0);
        rst_ni = 1'b1;

        // Table must be empty after reset: 0x40 and 0x0 both miss
        drive(0, 1, 32'h40, NOP, 32'h0, 0, 32'h0);
        step();
        check_all("post_rst_40", 32'h40, 0, 32'h44, 0, 0);
        drive(0, 1, 32'h0, NOP, 32'h0, 0, 32'h0);
        step();
        check_all("post_rst_0", 32'h0, 0, 32'h4, 0, 0);
        drive(0, 0, 32'h0, NOP, 32'h0, 0, 32'h0);
        step();
        check_all("post_rst_run", 32'h4, 0, 32'h8, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bp_fetch_pc_unit.md
Name: bp_fetch_pc_unit

Overview:
- Instruction-fetch PC generator with a direct-mapped two-bit branch predictor.
- Sits upstream of the hazard detection unit and owns the IF-stage PC register.
- Predicts the next fetch PC from a branch target table; consumes the EX-stage branch resolution (`comp_o`, `PC_jump_EX`, `PCSel_EX`, `alu`) to redirect and to train the table.
- Keeps branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16: number of predictor entries; power of two, ≥2.
- IDX_W, $clog2(ENTRIES): index width. Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 32: width of the statistics counters.

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `stall_PC`  in  1  hold the PC (from the hazard unit)
- `comp_i`  in  1  EX mispredict / redirect (hazard unit `comp_o`)
- `PC_jump_EX`  in  32  correct next PC for the EX instruction
- `op_ex`  in  7  EX opcode
- `pc_EX`  in  32  EX instruction PC
- `PCSel_EX`  in  1  EX branch resolved taken
- `alu`  in  32  EX branch/jump target
- `pc_IF`  out  32  current fetch PC (registered)
- `pred_taken`  out  1  prediction for `pc_IF`: hit and counter ≥ 2'b10
- `pred_target`  out  32  predicted next PC for `pc_IF`
- `br_cnt`  out  CNT_W  resolved control-transfer count
- `mispred_cnt`  out  CNT_W  mispredict count

Behaviour:
- Reset (async, `rst_ni`=0):
  - `pc_IF`=RESET_PC.
  - All entry valid bits=0, counters=2'b01, `br_cnt`=`mispred_cnt`=0.
  - Consequently `pred_taken`=0 and `pred_target`=RESET_PC+4.
  - Reset asserted mid-operation clears everything immediately; no pending update survives.
- Entry contents: valid, tag, 32-bit target, 2-bit counter.
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational on `pc_IF`):
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = `pred_taken` ? entry target : `pc_IF`+4 (mod 2^32, wraps).
- Next-PC priority, registered on the rising edge:
  1. `comp_i`: `pc_IF` ← `PC_jump_EX`. Overrides stall.
  2. `stall_PC`: `pc_IF` holds.
  3. Otherwise `pc_IF` ← `pred_target`.
- Update valid (upd) = `op_ex[6:4]`==3'b110, covering BRANCH/JAL/JALR. Applied on the edge, one update per cycle. Index and tag are taken from `pc_EX`.
  - Hit, taken (`PCSel_EX`=1): ctr saturating +1 (11 stays 11); target ← `alu`.
  - Hit, not taken: ctr saturating −1 (00 stays 00); target unchanged.
  - Miss, taken: allocate or overwrite entry: valid=1, tag, target=`alu`, ctr=2'b10.
  - Miss, not taken: no allocation, no change.
  - JAL/JALR train exactly as taken branches.
- Update is independent of `stall_PC`. A bubble in EX (flushed opcode, not 110xxxx) never trains.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass). The new contents are visible from the next cycle.
- Statistics:
  - `br_cnt` += 1 on every upd.
  - `mispred_cnt` += 1 when upd && `comp_i`.
  - Both wrap modulo 2^CNT_W.
- `comp_i` without upd (not produced by a correct hazard unit): still redirects, is not counted.

Test Plan:
- Reset then free-run, no stall/comp → `pc_IF` = 0, 4, 8, 12…; `pred_taken`=0; both counters 0.
- Branch at `pc_EX`=0x40, `PCSel_EX`=1, `alu`=0x100, `comp_i`=1, `PC_jump_EX`=0x100 → next `pc_IF`=0x100; `br_cnt`=1, `mispred_cnt`=1. A later fetch at 0x40 gives `pred_taken`=1, `pred_target`=0x100.
- Train 0x40 taken 3× → ctr=11. Then two not-taken resolutions → ctr=01, and fetch at 0x40 predicts 0x44. A further not-taken saturates at 00.
- `stall_PC`=1 for 3 cycles at `pc_IF`=0x20 → `pc_IF` stays 0x20. `comp_i`=1 with `PC_jump_EX`=0x80 during the stall → `pc_IF`=0x80 next cycle.
- Aliasing, ENTRIES=16: allocate 0x40, then taken branch at 0x80 (same index, different tag) → entry replaced; fetch at 0x40 now misses (`pred_target`=0x44).
- Same-cycle update and lookup at index of 0x40 → `pred_taken` reflects old state that cycle, new state the next. Assert `rst_ni` mid-run → `pc_IF`=0 immediately, table invalid.
